// File: rtl/mul_rr_scheduler.sv
// Round-robin arbiter sharing one in-order pipelined modular multiplier between NUM_IN requesters.
// Optional RESTORE_CTL_EN: hand each requester back its original ctl tag-field bits.
module mul_rr_scheduler #(
  parameter int unsigned NUM_IN       = 2,
  parameter int unsigned DAT_BITS     = 762,
  parameter int unsigned CTL_BITS     = 8,
  parameter int unsigned OVR_WRT_BIT  = 6,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  // requests from requesters
  input  logic [NUM_IN-1:0]                   i_axi_val,
  output logic [NUM_IN-1:0]                   i_axi_rdy,
  input  logic [NUM_IN-1:0][DAT_BITS-1:0]     i_axi_dat,
  input  logic [NUM_IN-1:0][CTL_BITS-1:0]     i_axi_ctl,
  input  logic [NUM_IN-1:0]                   i_axi_sop,
  input  logic [NUM_IN-1:0]                   i_axi_eop,
  // requests to multiplier
  output logic                                o_res_val,
  input  logic                                o_res_rdy,
  output logic [DAT_BITS-1:0]                 o_res_dat,
  output logic [CTL_BITS-1:0]                 o_res_ctl,
  output logic                                o_res_sop,
  output logic                                o_res_eop,
  // results from multiplier
  input  logic                                i_res_val,
  output logic                                i_res_rdy,
  input  logic [DAT_BITS-1:0]                 i_res_dat,
  input  logic [CTL_BITS-1:0]                 i_res_ctl,
  input  logic                                i_res_sop,
  input  logic                                i_res_eop,
  // results to requesters
  output logic [NUM_IN-1:0]                   o_axi_val,
  input  logic [NUM_IN-1:0]                   o_axi_rdy,
  output logic [NUM_IN-1:0][DAT_BITS-1:0]     o_axi_dat,
  output logic [NUM_IN-1:0][CTL_BITS-1:0]     o_axi_ctl,
  output logic [NUM_IN-1:0]                   o_axi_sop,
  output logic [NUM_IN-1:0]                   o_axi_eop,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   o_inflight,
  output logic                                o_tag_err
);

  localparam int unsigned TagBits = $clog2(NUM_IN);
  localparam int unsigned CntBits = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned OccBits = CntBits + 1;

  logic [TagBits-1:0]  rr_q;
  logic [TagBits-1:0]  gnt_idx;
  logic                gnt_found;
  logic [CTL_BITS-1:0] gnt_ctl;
  logic [CntBits-1:0]  inflight_q;
  logic [OccBits-1:0]  occupancy;
  logic                tag_err_q;
  logic                can_issue;
  logic                issue;
  logic                inc;
  logic                dec;
  logic                res_hs;
  logic                tag_ok;
  logic [TagBits-1:0]  res_tag;
  logic [CTL_BITS-1:0] ret_ctl;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    int unsigned        idx;
    logic [TagBits-1:0] idx_t;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    idx_t     = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      idx_t = TagBits'(idx);
      if (!gnt_found && i_axi_val[idx_t]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_t;
      end
    end
  end

  // The staged request counts toward the limit so the counter can never pass MAX_INFLIGHT.
  assign occupancy = {1'b0, inflight_q} + OccBits'(o_res_val);
  assign can_issue = (~o_res_val | o_res_rdy) & (occupancy < OccBits'(MAX_INFLIGHT));
  assign issue     = i_rst & can_issue & gnt_found;

  always_comb begin
    i_axi_rdy = '0;
    if (issue) i_axi_rdy[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_ctl = i_axi_ctl[gnt_idx];
    gnt_ctl[OVR_WRT_BIT +: TagBits] = gnt_idx;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_res_val <= 1'b0;
      o_res_dat <= '0;
      o_res_ctl <= '0;
      o_res_sop <= 1'b0;
      o_res_eop <= 1'b0;
      rr_q      <= '0;
    end else if (issue) begin
      o_res_val <= 1'b1;
      o_res_dat <= i_axi_dat[gnt_idx];
      o_res_ctl <= gnt_ctl;
      o_res_sop <= i_axi_sop[gnt_idx];
      o_res_eop <= i_axi_eop[gnt_idx];
      rr_q      <= (gnt_idx == TagBits'(NUM_IN - 1)) ? '0 : gnt_idx + TagBits'(1);
    end else if (o_res_rdy) begin
      o_res_val <= 1'b0;
    end
  end

  // Response routing by tag; out-of-range tags are swallowed.
  assign res_tag   = i_res_ctl[OVR_WRT_BIT +: TagBits];
  assign tag_ok    = 32'(res_tag) < NUM_IN;
  assign i_res_rdy = tag_ok ? o_axi_rdy[res_tag] : 1'b1;
  assign res_hs    = i_res_val & i_res_rdy;
  assign inc       = o_res_val & o_res_rdy;
  assign dec       = res_hs & (inflight_q != '0);

  always_comb begin
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      o_axi_val[k] = i_res_val & (res_tag == TagBits'(k));
      o_axi_dat[k] = i_res_dat;
      o_axi_ctl[k] = ret_ctl;
      o_axi_sop[k] = i_res_sop;
      o_axi_eop[k] = i_res_eop;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      inflight_q <= '0;
      tag_err_q  <= 1'b0;
    end else begin
      if (inc && !dec) begin
        inflight_q <= inflight_q + CntBits'(1);
      end else if (dec && !inc) begin
        inflight_q <= inflight_q - CntBits'(1);
      end
      if (res_hs && (!tag_ok || inflight_q == '0)) tag_err_q <= 1'b1;
    end
  end

  assign o_inflight = inflight_q;
  assign o_tag_err  = tag_err_q;

`ifdef RESTORE_CTL_EN
  localparam int unsigned PtrBits = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [PtrBits-1:0] PtrLast = PtrBits'(MAX_INFLIGHT - 1);

  logic [TagBits-1:0] fifo_mem [MAX_INFLIGHT];
  logic [PtrBits-1:0] wr_ptr_q;
  logic [PtrBits-1:0] rd_ptr_q;

  // Occupancy bounds the entry count, so no full/empty flags are needed.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (issue) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrBits'(1);
      if (dec)   rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrBits'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (issue) fifo_mem[wr_ptr_q] <= i_axi_ctl[gnt_idx][OVR_WRT_BIT +: TagBits];
  end

  always_comb begin
    ret_ctl = i_res_ctl;
    ret_ctl[OVR_WRT_BIT +: TagBits] = fifo_mem[rd_ptr_q];
  end
`else
  assign ret_ctl = i_res_ctl;
`endif

endmodule
